// File: rtl/gcd_controller_if.sv
// Handshake, comparator-flag and datapath-control bundle between the GCD
// controller (master) and its datapath/producer/consumer side (slave).
interface gcd_controller_if;
    logic        in_valid;
    logic        in_ready;
    logic        eq;
    logic        lt;
    logic        gt;
    logic        ldA;
    logic        ldB;
    logic        sel1;
    logic        sel2;
    logic        sel_in;
    logic        done;
    logic        err;
    logic        res_ack;
    logic [15:0] iter_cnt;

    modport master (
        input  in_valid, eq, lt, gt, res_ack,
        output in_ready, ldA, ldB, sel1, sel2, sel_in, done, err, iter_cnt
    );

    modport slave (
        output in_valid, eq, lt, gt, res_ack,
        input  in_ready, ldA, ldB, sel1, sel2, sel_in, done, err, iter_cnt
    );
endinterface

// File: rtl/gcd_controller.sv
// Subtractive-GCD controller: loads A then B from the shared data_in bus,
// steers one subtraction per cycle from the comparator flags until A==B,
// and aborts with err on a timeout or on a non-one-hot flag pattern.
module gcd_controller #(
    parameter logic [15:0] MAX_ITER = 16'hFFFF
) (
    input logic              clk,
    input logic              rst_n,
    gcd_controller_if.master bus
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        ITER   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] iter_q, iter_d;
    logic        err_q, err_d;

    logic        timeout;
    logic        flags_ok;
    logic        step_a;
    logic        step_b;

    // Saturating increment: the counter parks at MAX_ITER instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v >= MAX_ITER) ? MAX_ITER : v + 16'd1;
    endfunction

    // Timeout wins over a pending subtraction; an equal pair still finishes cleanly.
    assign timeout  = (iter_q >= MAX_ITER) && !bus.eq;
    assign flags_ok = $onehot({bus.eq, bus.lt, bus.gt});
    assign step_a   = (state_q == ITER) && !timeout && flags_ok && bus.gt;
    assign step_b   = (state_q == ITER) && !timeout && flags_ok && bus.lt;

    // State, iteration counter and abort flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            iter_q  <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
        end
    end

    // Next-state, counter and abort-flag logic.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        err_d   = err_q;
        unique case (state_q)
            LOAD_A: begin
                if (bus.in_valid) state_d = LOAD_B;
            end
            LOAD_B: begin
                if (bus.in_valid) begin
                    state_d = ITER;
                    iter_d  = 16'd0;
                end
            end
            ITER: begin
                if (timeout || !flags_ok) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if (bus.eq) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                end else begin
                    iter_d = sat_inc(iter_q);
                end
            end
            DONE: begin
                if (bus.res_ack) begin
                    state_d = LOAD_A;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase
    end

    // Datapath control outputs; everything is held low while reset is asserted.
    always_comb begin
        bus.in_ready = 1'b0;
        bus.sel_in   = 1'b0;
        bus.ldA      = 1'b0;
        bus.ldB      = 1'b0;
        bus.sel1     = 1'b0;
        bus.sel2     = 1'b0;
        bus.done     = 1'b0;
        bus.err      = 1'b0;
        bus.iter_cnt = iter_q;
        if (rst_n) begin
            unique case (state_q)
                LOAD_A: begin
                    bus.in_ready = 1'b1;
                    bus.sel_in   = 1'b1;
                    bus.ldA      = bus.in_valid;
                end
                LOAD_B: begin
                    bus.in_ready = 1'b1;
                    bus.sel_in   = 1'b1;
                    bus.ldB      = bus.in_valid;
                end
                ITER: begin
                    bus.ldA  = step_a;
                    bus.ldB  = step_b;
                    bus.sel1 = step_b;
                    bus.sel2 = step_a;
                end
                DONE: begin
                    bus.done = 1'b1;
                    bus.err  = err_q;
                end
                default: begin
                    bus.done = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: behavioural datapath around the controller,
// directed corner cases plus randomized operand pairs against a GCD model.
module tb_gcd_controller;

    localparam logic [15:0] MAX = 16'd8;

    logic clk;
    logic rst_n;
    gcd_controller_if bus ();

    gcd_controller #(.MAX_ITER(MAX)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] data_in;
    logic [15:0] regA, regB, sub;
    logic        force_en;
    logic [2:0]  force_flags;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: mux/subtractor/registers steered by the controller.
    always_comb sub = (bus.sel1 ? regB : regA) - (bus.sel2 ? regB : regA);

    always_ff @(posedge clk) begin
        if (bus.ldA) regA <= bus.sel_in ? data_in : sub;
        if (bus.ldB) regB <= bus.sel_in ? data_in : sub;
    end

    always_comb begin
        if (force_en) begin
            {bus.eq, bus.lt, bus.gt} = force_flags;
        end else begin
            bus.eq = (regA == regB);
            bus.lt = (regA < regB);
            bus.gt = (regA > regB);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int gcd_mod(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // One complete operation; starts and ends at a negedge in LOAD_A.
    task automatic run_pair(input logic [15:0] a, input logic [15:0] b,
                            input int stall_b, input int ack_wait);
        int  ra, rb, n;
        bit  exp_err;
        int  acts[$];
        logic [15:0] exp_a;

        // Reference: repeated subtraction of the smaller from the larger,
        // bounded by MAX subtractions.
        ra = a; rb = b; n = 0; exp_err = 0;
        forever begin
            if (ra == rb) begin exp_err = 0; break; end
            if (n == int'(MAX)) begin exp_err = 1; break; end
            if (ra > rb) begin acts.push_back(1); ra = ra - rb; end
            else         begin acts.push_back(2); rb = rb - ra; end
            n++;
        end
        exp_a = exp_err ? 16'(ra) : 16'(gcd_mod(a, b));

        bus.in_valid = 1'b1;
        data_in      = a;
        #1;
        chk("loadA_ready", bus.in_ready, 1);
        chk("loadA_selin", bus.sel_in, 1);
        chk("loadA_ldA", bus.ldA, 1);
        chk("loadA_ldB", bus.ldB, 0);
        step();

        for (int i = 0; i < stall_b; i++) begin
            bus.in_valid = 1'b0;
            data_in      = 16'hDEAD;
            #1;
            chk("stallB_ldB", bus.ldB, 0);
            chk("stallB_ready", bus.in_ready, 1);
            step();
        end

        bus.in_valid = 1'b1;
        data_in      = b;
        #1;
        chk("loadB_ready", bus.in_ready, 1);
        chk("loadB_ldB", bus.ldB, 1);
        chk("loadB_ldA", bus.ldA, 0);
        step();

        foreach (acts[i]) begin
            bus.in_valid = 1'($urandom_range(1));
            data_in      = 16'($urandom);
            #1;
            chk("iter_ldA", bus.ldA, (acts[i] == 1) ? 16'd1 : 16'd0);
            chk("iter_ldB", bus.ldB, (acts[i] == 2) ? 16'd1 : 16'd0);
            chk("iter_sel1", bus.sel1, (acts[i] == 2) ? 16'd1 : 16'd0);
            chk("iter_sel2", bus.sel2, (acts[i] == 1) ? 16'd1 : 16'd0);
            chk("iter_ready", bus.in_ready, 0);
            chk("iter_done", bus.done, 0);
            step();
        end

        #1;
        chk("final_ldA", bus.ldA, 0);
        chk("final_ldB", bus.ldB, 0);
        chk("final_done", bus.done, 0);
        step();

        for (int i = 0; i < ack_wait; i++) begin
            bus.in_valid = 1'($urandom_range(1));
            bus.res_ack  = 1'b0;
            #1;
            chk("done", bus.done, 1);
            chk("err", bus.err, 16'(exp_err));
            chk("iter_cnt", bus.iter_cnt, 16'(n));
            chk("resultA", regA, exp_a);
            chk("done_ldA", bus.ldA, 0);
            chk("done_ready", bus.in_ready, 0);
            step();
        end

        bus.res_ack  = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        chk("ack_done", bus.done, 1);
        chk("ack_err", bus.err, 16'(exp_err));
        chk("ack_resultA", regA, exp_a);
        chk("ack_ready", bus.in_ready, 0);
        chk("ack_ldA", bus.ldA, 0);
        step();

        bus.res_ack  = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("exit_done", bus.done, 0);
        chk("exit_err", bus.err, 0);
        chk("exit_ready", bus.in_ready, 1);
        chk("exit_iter_hold", bus.iter_cnt, 16'(n));
    endtask

    // Drive an illegal flag pattern in the first ITER cycle.
    task automatic illegal_flags(input logic [2:0] flags);
        bus.in_valid = 1'b1;
        data_in      = 16'd9;
        step();
        data_in      = 16'd4;
        step();
        bus.in_valid = 1'b0;
        force_en     = 1'b1;
        force_flags  = flags;
        #1;
        chk("ill_ldA", bus.ldA, 0);
        chk("ill_ldB", bus.ldB, 0);
        step();
        force_en = 1'b0;
        #1;
        chk("ill_done", bus.done, 1);
        chk("ill_err", bus.err, 1);
        chk("ill_iter", bus.iter_cnt, 0);
        bus.res_ack = 1'b1;
        step();
        bus.res_ack = 1'b0;
        #1;
        chk("ill_exit_err", bus.err, 0);
        chk("ill_exit_ready", bus.in_ready, 1);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.res_ack  = 1'b0;
        data_in      = 16'd0;
        force_en     = 1'b0;
        force_flags  = 3'b000;

        // Reset state
        #3;
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_ldA", bus.ldA, 0);
        chk("rst_selin", bus.sel_in, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_iter", bus.iter_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("post_rst_ready", bus.in_ready, 1);
        chk("post_rst_selin", bus.sel_in, 1);
        chk("post_rst_ldA_low", bus.ldA, 0);
        bus.in_valid = 1'b1;
        #1;
        chk("post_rst_ldA_high", bus.ldA, 1);
        bus.in_valid = 1'b0;

        // Directed operand pairs
        run_pair(16'd48, 16'd18, 0, 1);
        chk("p48_18_iter", bus.iter_cnt, 4);
        run_pair(16'd7, 16'd7, 0, 0);
        chk("p7_7_iter", bus.iter_cnt, 0);
        run_pair(16'd0, 16'd5, 0, 1);
        chk("p0_5_iter_sat", bus.iter_cnt, 8);
        run_pair(16'd12, 16'd8, 3, 5);

        // Non-one-hot flag patterns
        illegal_flags(3'b000);
        illegal_flags(3'b101);

        // Randomized operand pairs
        for (int k = 0; k < 20; k++) begin
            run_pair(16'($urandom_range(15)), 16'($urandom_range(15)),
                     int'($urandom_range(2)), int'($urandom_range(3)));
        end

        // Reset in the middle of ITER
        bus.in_valid = 1'b1;
        data_in      = 16'd30;
        step();
        data_in      = 16'd18;
        step();
        bus.in_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ldA", bus.ldA, 0);
        chk("midrst_ldB", bus.ldB, 0);
        chk("midrst_sel1", bus.sel1, 0);
        chk("midrst_sel2", bus.sel2, 0);
        chk("midrst_selin", bus.sel_in, 0);
        chk("midrst_ready", bus.in_ready, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_iter", bus.iter_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("relrst_ready", bus.in_ready, 1);
        chk("relrst_selin", bus.sel_in, 1);
        chk("relrst_done", bus.done, 0);
        chk("relrst_iter", bus.iter_cnt, 0);
        run_pair(16'd30, 16'd18, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gcd_controller.md
GCD_CONTROLLER -- requirements
Module: gcd_controller

Interface
REQ-001 Parameter: MAX_ITER, 16'hFFFF, maximum subtraction cycles per operand pair before timeout abort.
REQ-002 Clocking: one clock, clk; reset is asynchronous and active-low, named rst_n.
REQ-003 clk  input  1  rising-edge clock, shared with the GCD datapath.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand present on the datapath data_in bus.
REQ-006 in_ready  output  1  controller accepts operand; transfer occurs on the clk edge where in_valid && in_ready.
REQ-007 eq, lt, gt  input  1 each  datapath comparator flags for A==B, A<B, A>B.
REQ-008 ldA, ldB  output  1 each  datapath register A / B load enables.
REQ-009 sel1, sel2  output  1 each  subtractor operand selects: X and Y (0 = A, 1 = B).
REQ-010 sel_in  output  1  bus select (1 = data_in, 0 = subtractor output).
REQ-011 done  output  1  result valid; datapath A holds the GCD.
REQ-012 err  output  1  qualifies done: run aborted (timeout or illegal flags).
REQ-013 res_ack  input  1  consumer accepts result while done=1.
REQ-014 iter_cnt  output  16  subtraction cycles performed in the current or last run.

Function
REQ-015 States: LOAD_A (reset state), LOAD_B, ITER, DONE; state register updated on rising clk.
REQ-016 LOAD_A: in_ready=1, sel_in=1, ldA=in_valid; on transfer go to LOAD_B.
REQ-017 LOAD_B: in_ready=1, sel_in=1, ldB=in_valid; on transfer go to ITER, clear iter_cnt to 0.
REQ-018 ITER: in_ready=0 and sel_in=0; ldA/ldB/sel1/sel2 are Mealy functions of the flags in the same cycle.
REQ-019 ITER, gt only: ldA=1, sel1=0, sel2=1 (A <= A-B); iter_cnt increments.
REQ-020 ITER, lt only: ldB=1, sel1=1, sel2=0 (B <= B-A); iter_cnt increments.
REQ-021 ITER, eq only: no load; next state DONE with err=0.
REQ-022 ITER, flags not exactly one-hot (none or several): no load; next state DONE with err=1.
REQ-023 ITER, iter_cnt==MAX_ITER and eq=0: no load, no increment; next state DONE with err=1. Timeout check takes priority over REQ-019/020.
REQ-024 Throughput: one subtraction per clk cycle in ITER; flags from the updated registers are valid on the following cycle.
REQ-025 DONE: done=1 (Moore, registered state decode); err holds its captured value; all loads=0; in_ready=0; sel1=sel2=sel_in=0.
REQ-026 DONE with res_ack=1: next state LOAD_A; err clears on exit. iter_cnt holds until the next LOAD_B transfer.
REQ-027 res_ack outside DONE: ignored. in_valid outside LOAD_A/LOAD_B: ignored, no load.
REQ-028 Default for any output not specified in a state: 0.
REQ-029 iter_cnt saturates at MAX_ITER and never wraps.

Reset
REQ-030 rst_n low: state=LOAD_A immediately (asynchronous); iter_cnt=0; done=err=0; ldA=ldB=sel1=sel2=sel_in=0; in_ready=0 while rst_n is low.
REQ-031 Reset mid-run (any state) abandons the operation; no load is asserted during reset.
REQ-032 After rst_n rises: in_ready=1 and sel_in=1 on the first cycle; ldA follows in_valid.

Verification
REQ-033 A=48, B=18 -> ITER cycles load in order ldA, ldA, ldB, ldA, then eq; done=1 in the 6th cycle after the B transfer edge; A=6; iter_cnt=4; err=0.
REQ-034 A=7, B=7 -> eq in the first ITER cycle; no ldA/ldB; done=1 the next cycle; iter_cnt=0; err=0.
REQ-035 MAX_ITER=8, A=0, B=5 -> lt persists; 8 ldB pulses; then done=1, err=1, iter_cnt=8.
REQ-036 in_valid held low 3 cycles in LOAD_B -> ldB=0 and state remains LOAD_B; load proceeds on the cycle in_valid rises.
REQ-037 done held 5 cycles with res_ack=0, then res_ack=1 with in_valid=1 -> no transfer that cycle; next cycle LOAD_A with in_ready=1 and new A loaded.
REQ-038 rst_n pulsed low during ITER (A=30, B=18) -> all outputs 0 asynchronously; after release state is LOAD_A and iter_cnt=0.
